// File: rtl/video_scanlines_pkg.sv
// Shared constants for the CRT scanline stage. Pipeline depth follows the
// optional VIDEO_SCANLINES_BLEND_EN horizontal-blend stage.
package video_scanlines_pkg;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_25  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_75  = 2'd3;

`ifdef VIDEO_SCANLINES_BLEND_EN
  localparam int unsigned PIPE_DEPTH = 3;
`else
  localparam int unsigned PIPE_DEPTH = 2;
`endif

  function automatic int unsigned chan_width(input int unsigned half_depth);
    return (half_depth != 0) ? 4 : 8;
  endfunction

endpackage

// File: rtl/video_scanlines_if.sv
// Video stream bundle: syncs, blanks and one RGB pixel. The master drives it,
// the slave consumes it.
interface video_scanlines_if
  import video_scanlines_pkg::*;
#(
  parameter int unsigned DWIDTH = chan_width(0) - 1
) ();

  logic            hs;
  logic            vs;
  logic            hb;
  logic            vb;
  logic [DWIDTH:0] r;
  logic [DWIDTH:0] g;
  logic [DWIDTH:0] b;

  modport master (output hs, vs, hb, vb, r, g, b);
  modport slave  (input  hs, vs, hb, vb, r, g, b);

endinterface

// File: rtl/video_scanlines_dim.sv
// Single-channel scanline darkening with blanking override; purely
// combinational.
module scanline_dim
  import video_scanlines_pkg::*;
#(
  parameter int unsigned DWIDTH = 7
) (
  input  logic [DWIDTH:0] in,
  input  logic [1:0]      mode,
  input  logic            dim_en,
  input  logic            blank,
  output logic [DWIDTH:0] out
);

  always_comb begin
    out = in;
    if (blank) begin
      out = '0;
    end else if (dim_en) begin
      case (mode)
        SL_25:   out = in - (in >> 2);
        SL_50:   out = in >> 1;
        SL_75:   out = in >> 2;
        default: out = in;
      endcase
    end
  end

endmodule

// File: rtl/video_scanlines.sv
// Darkens every second scan-doubled line. Optional horizontal blend stage is
// enabled with VIDEO_SCANLINES_BLEND_EN (adds one enable of latency).
module video_scanlines
  import video_scanlines_pkg::*;
#(
  parameter int unsigned HALF_DEPTH = 0
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic [1:0] scanlines,
  video_scanlines_if.slave  vid_in,
  video_scanlines_if.master vid_out
);

  localparam int unsigned DWIDTH = chan_width(HALF_DEPTH) - 1;

  // Control bundles are packed as {hs, vs, hb, vb}.
  logic [3:0]      s0_ctl;
  logic [DWIDTH:0] s0_r, s0_g, s0_b;

`ifdef VIDEO_SCANLINES_BLEND_EN
  logic [DWIDTH:0] prev_r_q, prev_g_q, prev_b_q;
  logic [DWIDTH:0] s0_r_q, s0_g_q, s0_b_q;
  logic [3:0]      s0_ctl_q;

  function automatic logic [DWIDTH:0] blend_avg(input logic [DWIDTH:0] a,
                                                input logic [DWIDTH:0] b);
    logic [DWIDTH+1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DWIDTH+1:1];
  endfunction

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prev_r_q <= '0;
      prev_g_q <= '0;
      prev_b_q <= '0;
      s0_r_q   <= '0;
      s0_g_q   <= '0;
      s0_b_q   <= '0;
      s0_ctl_q <= '0;
    end else if (ce_pix) begin
      // Blanked pixels leave black behind so a line's first pixel blends with 0.
      prev_r_q <= vid_in.hb ? '0 : vid_in.r;
      prev_g_q <= vid_in.hb ? '0 : vid_in.g;
      prev_b_q <= vid_in.hb ? '0 : vid_in.b;
      s0_r_q   <= blend_avg(vid_in.r, prev_r_q);
      s0_g_q   <= blend_avg(vid_in.g, prev_g_q);
      s0_b_q   <= blend_avg(vid_in.b, prev_b_q);
      s0_ctl_q <= {vid_in.hs, vid_in.vs, vid_in.hb, vid_in.vb};
    end
  end

  assign s0_ctl = s0_ctl_q;
  assign s0_r   = s0_r_q;
  assign s0_g   = s0_g_q;
  assign s0_b   = s0_b_q;
`else
  assign s0_ctl = {vid_in.hs, vid_in.vs, vid_in.hb, vid_in.vb};
  assign s0_r   = vid_in.r;
  assign s0_g   = vid_in.g;
  assign s0_b   = vid_in.b;
`endif

  logic       hs_q, vs_q;
  logic       odd_q, odd_d;
  logic [1:0] mode_q, mode_d;
  logic       line_start, frame_start;

  assign line_start  = hs_q & ~s0_ctl[3];
  assign frame_start = ~vs_q & s0_ctl[2];

  // Frame start overrides a coincident line start.
  always_comb begin
    odd_d  = odd_q;
    mode_d = mode_q;
    if (frame_start) begin
      odd_d  = 1'b0;
      mode_d = scanlines;
    end else if (line_start) begin
      odd_d = ~odd_q;
    end
  end

  logic [DWIDTH:0] s1_r_q, s1_g_q, s1_b_q;
  logic [3:0]      s1_ctl_q;
  logic            s1_odd_q;
  logic [1:0]      s1_mode_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      odd_q     <= 1'b0;
      mode_q    <= SL_OFF;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      s1_ctl_q  <= '0;
      s1_odd_q  <= 1'b0;
      s1_mode_q <= SL_OFF;
    end else if (ce_pix) begin
      hs_q      <= s0_ctl[3];
      vs_q      <= s0_ctl[2];
      odd_q     <= odd_d;
      mode_q    <= mode_d;
      s1_r_q    <= s0_r;
      s1_g_q    <= s0_g;
      s1_b_q    <= s0_b;
      s1_ctl_q  <= s0_ctl;
      // Post-update parity: the pixel at the hsync fall already belongs to the new line.
      s1_odd_q  <= odd_d;
      s1_mode_q <= mode_d;
    end
  end

  logic            dim_en, blank;
  logic [DWIDTH:0] dim_r, dim_g, dim_b;

  assign dim_en = s1_odd_q & (s1_mode_q != SL_OFF);
  assign blank  = s1_ctl_q[1] | s1_ctl_q[0];

  scanline_dim #(.DWIDTH(DWIDTH)) u_dim_r (
    .in     (s1_r_q),
    .mode   (s1_mode_q),
    .dim_en (dim_en),
    .blank  (blank),
    .out    (dim_r)
  );

  scanline_dim #(.DWIDTH(DWIDTH)) u_dim_g (
    .in     (s1_g_q),
    .mode   (s1_mode_q),
    .dim_en (dim_en),
    .blank  (blank),
    .out    (dim_g)
  );

  scanline_dim #(.DWIDTH(DWIDTH)) u_dim_b (
    .in     (s1_b_q),
    .mode   (s1_mode_q),
    .dim_en (dim_en),
    .blank  (blank),
    .out    (dim_b)
  );

  logic [DWIDTH:0] out_r_q, out_g_q, out_b_q;
  logic [3:0]      out_ctl_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      out_r_q   <= '0;
      out_g_q   <= '0;
      out_b_q   <= '0;
      out_ctl_q <= '0;
    end else if (ce_pix) begin
      out_r_q   <= dim_r;
      out_g_q   <= dim_g;
      out_b_q   <= dim_b;
      out_ctl_q <= s1_ctl_q;
    end
  end

  assign vid_out.hs = out_ctl_q[3];
  assign vid_out.vs = out_ctl_q[2];
  assign vid_out.hb = out_ctl_q[1];
  assign vid_out.vb = out_ctl_q[0];
  assign vid_out.r  = out_r_q;
  assign vid_out.g  = out_g_q;
  assign vid_out.b  = out_b_q;

endmodule

// File: tb/tb_video_scanlines.sv
// Bench for video_scanlines: randomised enables and colours against a
// per-pixel reference model, plus directed checks on known values.
module tb_video_scanlines;
  import video_scanlines_pkg::*;

  localparam int LINE   = 16;
  localparam int ACT    = 10;
  localparam int VS_PIX = 11;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix  = 1'b0;
  logic [1:0] scanlines = 2'd0;

  video_scanlines_if #(.DWIDTH(7)) vi ();
  video_scanlines_if #(.DWIDTH(7)) vo ();

  video_scanlines #(.HALF_DEPTH(0)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .scanlines (scanlines),
    .vid_in    (vi),
    .vid_out   (vo)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [27:0] act_now, exp_now;

  // Reference model state
  logic        m_hs, m_vs, m_odd;
  int          m_mode;
  logic [7:0]  m_pr, m_pg, m_pb;
  logic [27:0] m_q[$];

  function automatic logic [27:0] pack_out();
    return {vo.hs, vo.vs, vo.hb, vo.vb, vo.r, vo.g, vo.b};
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] c, input int m);
    int v;
    v = int'(c);
    case (m)
      1:       v = v - v / 4;
      2:       v = v / 2;
      3:       v = v / 4;
      default: v = v;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [3:0] ctl(input int ln, input int p, input int vs_pix,
                                     input int vb_lines);
    logic hs, vs, hb, vb;
    hs = (p == 11) || (p == 12);
    hb = (p >= ACT);
    vs = (ln == 0 && p >= vs_pix) || (ln == 1 && p < vs_pix);
    vb = (ln < vb_lines);
    return {hs, vs, hb, vb};
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < int'(PIPE_DEPTH) - 1; i++) m_q.push_back('0);
    m_hs = 1'b0; m_vs = 1'b0; m_odd = 1'b0; m_mode = 0;
    m_pr = '0; m_pg = '0; m_pb = '0;
    exp_now = '0;
  endtask

  // One pixel on one enable, after 0..2 idle clocks; updates act_now/exp_now.
  task automatic step(input logic [3:0] c, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    logic hs, vs, hb, vb;
    logic [7:0] cr, cg, cb;
    {hs, vs, hb, vb} = c;
    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    vi.hs = hs; vi.vs = vs; vi.hb = hb; vi.vb = vb;
    vi.r = r; vi.g = g; vi.b = b;
    ce_pix = 1'b1;
    @(negedge clk_sys);
    ce_pix = 1'b0;
    if (vs && !m_vs) begin
      m_odd = 1'b0;
      m_mode = int'(scanlines);
    end else if (m_hs && !hs) begin
      m_odd = !m_odd;
    end
    m_hs = hs; m_vs = vs;
    cr = r; cg = g; cb = b;
`ifdef VIDEO_SCANLINES_BLEND_EN
    cr = 8'((int'(r) + int'(m_pr)) / 2);
    cg = 8'((int'(g) + int'(m_pg)) / 2);
    cb = 8'((int'(b) + int'(m_pb)) / 2);
    m_pr = hb ? 8'h00 : r;
    m_pg = hb ? 8'h00 : g;
    m_pb = hb ? 8'h00 : b;
`endif
    if (hb || vb) begin
      cr = '0; cg = '0; cb = '0;
    end else if (m_odd && m_mode != 0) begin
      cr = dim(cr, m_mode); cg = dim(cg, m_mode); cb = dim(cb, m_mode);
    end
    m_q.push_back({hs, vs, hb, vb, cr, cg, cb});
    exp_now = m_q.pop_front();
    act_now = pack_out();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce_pix = 1'b1;
    repeat (3) @(negedge clk_sys);
    act_now = pack_out();
    n_cmp++;
    if (act_now !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_hold actual=%h required=%h", act_now, 28'h0);
    end
    reset_n = 1'b1;
    ce_pix = 1'b0;
    model_reset();
    @(negedge clk_sys);
    act_now = pack_out();
    n_cmp++;
    if (act_now !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_release actual=%h required=%h", act_now, 28'h0);
    end
  endtask

  task automatic test_mode2_dim();
    int og, oln, op;
    logic [7:0] want;
    scanlines = 2'd2;
    for (int g = 0; g < 4 * LINE; g++) begin
      step(ctl(g / LINE, g % LINE, VS_PIX, 2), 8'hC8, 8'h10, 8'h20);
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL mode2_model g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
      og = g - int'(PIPE_DEPTH) + 1;
      oln = og / LINE; op = og % LINE;
      if (og >= 0 && oln >= 2 && op >= 1 && op < ACT) begin
        want = (oln == 2) ? 8'hC8 : 8'h64;
        n_cmp++;
        if (vo.r !== want) begin
          n_fail++;
          $display("FAIL mode2_r line=%0d px=%0d actual=%h required=%h", oln, op, vo.r, want);
        end
      end
    end
  endtask

  task automatic test_mode_change();
    int og, oln, op;
    logic [7:0] want;
    scanlines = 2'd2;
    for (int g = 0; g < 6 * LINE; g++) begin
      if (g == 3 * LINE) scanlines = 2'd3;
      step(ctl(g / LINE, g % LINE, VS_PIX, 2), 8'hC8, 8'($urandom), 8'($urandom));
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL modechg_model g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
      og = g - int'(PIPE_DEPTH) + 1;
      oln = og / LINE; op = og % LINE;
      if (og >= 0 && oln >= 2 && op >= 1 && op < ACT) begin
        want = (oln % 2 == 1) ? 8'h64 : 8'hC8;
        n_cmp++;
        if (vo.r !== want) begin
          n_fail++;
          $display("FAIL modechg_old line=%0d actual=%h required=%h", oln, vo.r, want);
        end
      end
    end
    for (int g = 0; g < 4 * LINE; g++) begin
      step(ctl(g / LINE, g % LINE, VS_PIX, 2), 8'hC8, 8'($urandom), 8'($urandom));
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL modechg_model2 g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
      og = g - int'(PIPE_DEPTH) + 1;
      oln = og / LINE; op = og % LINE;
      if (og >= 0 && oln == 3 && op >= 1 && op < ACT) begin
        n_cmp++;
        if (vo.r !== 8'h32) begin
          n_fail++;
          $display("FAIL modechg_new px=%0d actual=%h required=%h", op, vo.r, 8'h32);
        end
      end
    end
  endtask

  task automatic test_blank_mode1();
    int og, oln, op;
    for (int m = 0; m < 4; m++) begin
      scanlines = 2'(m);
      for (int g = 0; g < 4 * LINE; g++) begin
        step(ctl(g / LINE, g % LINE, VS_PIX, 2), 8'hFF, 8'($urandom), 8'($urandom));
        n_cmp++;
        if (act_now !== exp_now) begin
          n_fail++;
          $display("FAIL blank_model m=%0d g=%0d actual=%h required=%h",
                   m, g, act_now, exp_now);
        end
        og = g - int'(PIPE_DEPTH) + 1;
        oln = og / LINE; op = og % LINE;
        if (og >= 0 && (oln < 2 || op >= ACT)) begin
          n_cmp++;
          if (vo.r !== 8'h00) begin
            n_fail++;
            $display("FAIL blank_r m=%0d line=%0d px=%0d actual=%h required=00",
                     m, oln, op, vo.r);
          end
        end else if (og >= 0 && m == 1 && oln == 3 && op >= 1) begin
          n_cmp++;
          if (vo.r !== 8'hC0) begin
            n_fail++;
            $display("FAIL mode1_r px=%0d actual=%h required=%h", op, vo.r, 8'hC0);
          end
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int og, oln, op;
    logic [7:0] want;
    scanlines = 2'd2;
    for (int g = 0; g < 3 * LINE; g++) begin
      step(ctl(g / LINE, g % LINE, 13, 1), 8'hC8, 8'($urandom), 8'($urandom));
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL simul_model g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
      og = g - int'(PIPE_DEPTH) + 1;
      oln = og / LINE; op = og % LINE;
      if (og >= 0 && oln >= 1 && op >= 1 && op < ACT) begin
        want = (oln == 1) ? 8'hC8 : 8'h64;
        n_cmp++;
        if (vo.r !== want) begin
          n_fail++;
          $display("FAIL simul_r line=%0d actual=%h required=%h", oln, vo.r, want);
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      vi.r = 8'($urandom); vi.g = 8'($urandom); vi.b = 8'($urandom);
      vi.hs = 1'($urandom); vi.vs = 1'($urandom);
      vi.hb = 1'($urandom); vi.vb = 1'($urandom);
      @(negedge clk_sys);
      act_now = pack_out();
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL ce_hold clk=%0d actual=%h required=%h", i, act_now, exp_now);
      end
    end
  endtask

  task automatic test_reset_midline();
    int og, oln, op;
    scanlines = 2'd2;
    for (int g = 0; g < 4 * LINE; g++) begin
      if (g == 2 * LINE + 5) begin
        reset_n = 1'b0;
        ce_pix = 1'($urandom);
        @(negedge clk_sys);
        reset_n = 1'b1;
        ce_pix = 1'b0;
        model_reset();
        act_now = pack_out();
        n_cmp++;
        if (act_now !== 28'h0) begin
          n_fail++;
          $display("FAIL reset_mid actual=%h required=%h", act_now, 28'h0);
        end
      end
      step(ctl(g / LINE, g % LINE, VS_PIX, 2), 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL resetmid_model g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
    end
    for (int g = 0; g < 4 * LINE; g++) begin
      step(ctl(g / LINE, g % LINE, VS_PIX, 2), 8'hC8, 8'hC8, 8'hC8);
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL resetmid_model2 g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
      og = g - int'(PIPE_DEPTH) + 1;
      oln = og / LINE; op = og % LINE;
      if (og >= 0 && oln == 3 && op >= 1 && op < ACT) begin
        n_cmp++;
        if (vo.g !== 8'h64) begin
          n_fail++;
          $display("FAIL resetmid_dim px=%0d actual=%h required=%h", op, vo.g, 8'h64);
        end
      end
    end
  endtask

  task automatic test_random();
    int vsp, vbl;
    for (int f = 0; f < 4; f++) begin
      scanlines = 2'($urandom);
      vsp = ($urandom_range(0, 1) != 0) ? 13 : VS_PIX;
      vbl = $urandom_range(1, 2);
      for (int g = 0; g < 5 * LINE; g++) begin
        step(ctl(g / LINE, g % LINE, vsp, vbl), 8'($urandom), 8'($urandom), 8'($urandom));
        n_cmp++;
        if (act_now !== exp_now) begin
          n_fail++;
          $display("FAIL random_model f=%0d g=%0d actual=%h required=%h",
                   f, g, act_now, exp_now);
        end
      end
    end
  endtask

  task automatic test_blend();
`ifdef VIDEO_SCANLINES_BLEND_EN
    int og, oln, op;
    logic [7:0] pix [3];
    logic [7:0] want [3];
    logic [7:0] r;
    pix  = '{8'h00, 8'hFE, 8'hFE};
    want = '{8'h00, 8'h7F, 8'hFE};
    scanlines = 2'd0;
    for (int g = 0; g < 3 * LINE; g++) begin
      r = 8'($urandom);
      if (g / LINE == 2) r = (g % LINE < 3) ? pix[g % LINE] : 8'hFE;
      step(ctl(g / LINE, g % LINE, VS_PIX, 2), r, r, r);
      n_cmp++;
      if (act_now !== exp_now) begin
        n_fail++;
        $display("FAIL blend_model g=%0d actual=%h required=%h", g, act_now, exp_now);
      end
      og = g - 2;
      oln = og / LINE; op = og % LINE;
      if (og >= 0 && oln == 2 && op < 3) begin
        n_cmp++;
        if (vo.r !== want[op]) begin
          n_fail++;
          $display("FAIL blend_r px=%0d actual=%h required=%h", op, vo.r, want[op]);
        end
      end
      if (og >= 0 && oln == 1 && (op == 11 || op == 12)) begin
        n_cmp++;
        if (vo.hs !== 1'b1) begin
          n_fail++;
          $display("FAIL blend_hs px=%0d actual=%b required=1", op, vo.hs);
        end
      end
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vi.hs = 1'b0; vi.vs = 1'b0; vi.hb = 1'b0; vi.vb = 1'b0;
    vi.r = '0; vi.g = '0; vi.b = '0;
    model_reset();
    @(negedge clk_sys);
    test_reset();
    test_mode2_dim();
    test_mode_change();
    test_blank_mode1();
    test_simultaneous();
    test_reset_midline();
    test_random();
    test_blend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
